// File: rtl/pipo_load_arbiter_if.sv
// Bus between the two load requesters and the shared PIPO load arbiter.
// Defining PIPO_ARB_STATS_EN adds the 8-bit load_cnt statistics signal.
interface pipo_load_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [1:0]       ack;
  logic             reg_load;
  logic [WIDTH-1:0] reg_data;
  logic             owner;
  logic             busy;
`ifdef PIPO_ARB_STATS_EN
  logic [7:0]       load_cnt;

  modport master (
    output req, data0, data1,
    input  ack, reg_load, reg_data, owner, busy, load_cnt
  );

  modport slave (
    input  req, data0, data1,
    output ack, reg_load, reg_data, owner, busy, load_cnt
  );
`else
  modport master (
    output req, data0, data1,
    input  ack, reg_load, reg_data, owner, busy
  );

  modport slave (
    input  req, data0, data1,
    output ack, reg_load, reg_data, owner, busy
  );
`endif
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter granting two requesters one-cycle load strobes into a shared PIPO register.
// Optional feature macro: PIPO_ARB_STATS_EN (saturating 8-bit load counter on bus.load_cnt).
module pipo_load_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  pipo_load_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ACK  = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             winner_s;
  logic             last_r;
  logic             owner_r;
  logic [WIDTH-1:0] reg_data_r;
  logic             reg_load_r;
  logic [1:0]       ack_r;
  logic             busy_r;

  function automatic logic [1:0] ack_mask(input logic idx);
    if (idx) begin
      ack_mask = 2'b10;
    end else begin
      ack_mask = 2'b01;
    end
  endfunction

  // Round-robin pick: a sole requester wins, on a tie the one that did not win last time.
  always_comb begin
    winner_s = 1'b0;
    case (bus.req)
      2'b01:   winner_s = 1'b0;
      2'b10:   winner_s = 1'b1;
      2'b11:   winner_s = ~last_r;
      default: winner_s = 1'b0;
    endcase
  end

  // Next-state logic; a withdrawn request never aborts LOAD, ACK lasts while the owner holds req.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req != 2'b00) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: state_next_s = ACK;
      ACK: begin
        if (bus.req[owner_r]) begin
          state_next_s = ACK;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered outputs are decoded from the next state so they line up with state_r.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_load_r <= 1'b0;
      ack_r      <= 2'b00;
      busy_r     <= 1'b0;
    end else begin
      reg_load_r <= (state_next_s == LOAD);
      busy_r     <= (state_next_s != IDLE);
      if (state_next_s == ACK) begin
        ack_r <= ack_mask(owner_r);
      end else begin
        ack_r <= 2'b00;
      end
    end
  end

  // Grant capture: data is sampled only on the IDLE->LOAD edge; last winner resets to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r    <= 1'b0;
      last_r     <= 1'b1;
      reg_data_r <= '0;
    end else if ((state_r == IDLE) && (state_next_s == LOAD)) begin
      owner_r    <= winner_s;
      last_r     <= winner_s;
      reg_data_r <= winner_s ? bus.data1 : bus.data0;
    end else begin
      owner_r    <= owner_r;
      last_r     <= last_r;
      reg_data_r <= reg_data_r;
    end
  end

  assign bus.reg_load = reg_load_r;
  assign bus.ack      = ack_r;
  assign bus.busy     = busy_r;
  assign bus.owner    = owner_r;
  assign bus.reg_data = reg_data_r;

`ifdef PIPO_ARB_STATS_EN
  logic [7:0] load_cnt_r;

  // Saturating count of cycles spent in LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_cnt_r <= 8'd0;
    end else if ((state_r == LOAD) && (load_cnt_r != 8'hFF)) begin
      load_cnt_r <= load_cnt_r + 8'd1;
    end else begin
      load_cnt_r <= load_cnt_r;
    end
  end

  assign bus.load_cnt = load_cnt_r;
`endif

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Self-checking bench for pipo_load_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model. Stats checks are built when PIPO_ARB_STATS_EN is defined.
module tb_pipo_load_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  pipo_load_arbiter_if #(.WIDTH(4)) bus ();

  pipo_load_arbiter #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Observation vector: {reg_load, ack[1:0], busy, owner, reg_data[3:0]}
  function automatic logic [8:0] snap();
    return {bus.reg_load, bus.ack, bus.busy, bus.owner, bus.reg_data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.req   = 2'b00;
    bus.data0 = 4'h0;
    bus.data1 = 4'h0;
    reset     = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    bus.req   = 2'b01;
    bus.data0 = 4'hF;
    bus.data1 = 4'hF;
    reset     = 1'b0;
    #1;
    got = snap();
    checks++;
    if (got !== 9'b0_00_0_0_0000) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected %b", got, 9'b0_00_0_0_0000);
    end
    apply_reset();
    got = snap();
    checks++;
    if (got !== 9'b0_00_0_0_0000) begin
      fails++;
      $display("FAIL reset_release: got %b expected %b", got, 9'b0_00_0_0_0000);
    end
  endtask

  task automatic test_single_request();
    logic [1:0] rq [5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    logic [8:0] ex [5] = '{9'b1_00_1_0_1010, 9'b0_01_1_0_1010, 9'b0_01_1_0_1010,
                           9'b0_00_0_0_1010, 9'b0_00_0_0_1010};
    logic [8:0] got;
    apply_reset();
    bus.data0 = 4'b1010;
    bus.data1 = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      bus.req = rq[i];
      tick();
      got = snap();
      checks++;
      if (got !== ex[i]) begin
        fails++;
        $display("FAIL single step %0d: got %b expected %b", i, got, ex[i]);
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] rq [6] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
    logic [8:0] ex [6] = '{9'b1_00_1_0_0101, 9'b0_01_1_0_0101, 9'b0_00_0_0_0101,
                           9'b1_00_1_1_1111, 9'b0_10_1_1_1111, 9'b0_00_0_1_1111};
    logic [8:0] got;
    apply_reset();
    bus.data0 = 4'b0101;
    bus.data1 = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      bus.req = rq[i];
      tick();
      got = snap();
      checks++;
      if (got !== ex[i]) begin
        fails++;
        $display("FAIL contention step %0d: got %b expected %b", i, got, ex[i]);
      end
    end
  endtask

  task automatic test_withdrawn();
    logic [1:0] rq [4] = '{2'b10, 2'b00, 2'b00, 2'b00};
    logic [8:0] ex [4] = '{9'b1_00_1_1_0011, 9'b0_10_1_1_0011, 9'b0_00_0_1_0011,
                           9'b0_00_0_1_0011};
    logic [8:0] got;
    apply_reset();
    bus.data0 = 4'b1100;
    bus.data1 = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      bus.req = rq[i];
      if (i == 1) begin
        bus.data1 = 4'b1000;
      end
      tick();
      got = snap();
      checks++;
      if (got !== ex[i]) begin
        fails++;
        $display("FAIL withdrawn step %0d: got %b expected %b", i, got, ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid_ack();
    logic [8:0] got;
    apply_reset();
    bus.data0 = 4'b0110;
    bus.req   = 2'b01;
    tick();
    tick();
    got = snap();
    checks++;
    if (got !== 9'b0_01_1_0_0110) begin
      fails++;
      $display("FAIL mid_ack_before_reset: got %b expected %b", got, 9'b0_01_1_0_0110);
    end
    #2;
    reset = 1'b0;
    #1;
    got = snap();
    checks++;
    if (got !== 9'b0) begin
      fails++;
      $display("FAIL mid_ack_async_reset: got %b expected %b", got, 9'b0);
    end
    bus.req = 2'b00;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      got = snap();
      checks++;
      if (got !== 9'b0) begin
        fails++;
        $display("FAIL mid_ack_after_release %0d: got %b expected %b", i, got, 9'b0);
      end
    end
  endtask

  task automatic test_fairness();
    int         grants;
    logic       exp_owner;
    logic [3:0] exp_data;
    logic [1:0] r;
    apply_reset();
    grants    = 0;
    bus.data0 = 4'b0001;
    bus.data1 = 4'b1110;
    bus.req   = 2'b11;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.reg_load) begin
        exp_owner = grants[0];
        exp_data  = exp_owner ? 4'b1110 : 4'b0001;
        checks++;
        if ({bus.owner, bus.reg_data} !== {exp_owner, exp_data}) begin
          fails++;
          $display("FAIL fairness grant %0d: got owner %0d data %b expected owner %0d data %b",
                   grants, bus.owner, bus.reg_data, exp_owner, exp_data);
        end
        grants++;
      end
      r = bus.req;
      for (int i = 0; i < 2; i++) begin
        r[i] = ~bus.ack[i];
      end
      bus.req = r;
    end
    checks++;
    if (grants < 15) begin
      fails++;
      $display("FAIL fairness_grant_count: got %0d expected at least %0d", grants, 15);
    end
  endtask

  // Transaction-level model: a grant is pending from the arbitration edge, shows one load cycle,
  // then acknowledges until the winner is seen without a request.
  task automatic test_random();
    bit         m_active;
    bit         m_loading;
    bit         m_win;
    bit         m_last;
    logic [3:0] m_data;
    logic [1:0] m_ack;
    logic [1:0] r;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [8:0] exp;
    logic [8:0] got;
    apply_reset();
    m_active  = 1'b0;
    m_loading = 1'b0;
    m_win     = 1'b0;
    m_last    = 1'b1;
    m_data    = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        got = snap();
        checks++;
        if (got !== 9'b0) begin
          fails++;
          $display("FAIL random_reset cycle %0d: got %b expected %b", c, got, 9'b0);
        end
        m_active  = 1'b0;
        m_loading = 1'b0;
        m_win     = 1'b0;
        m_last    = 1'b1;
        m_data    = 4'h0;
        tick();
        reset = 1'b1;
      end
      r  = 2'($urandom_range(0, 3));
      d0 = 4'($urandom);
      d1 = 4'($urandom);
      bus.req   = r;
      bus.data0 = d0;
      bus.data1 = d1;
      tick();
      if (!m_active) begin
        if (r != 2'b00) begin
          m_win     = (r == 2'b11) ? !m_last : r[1];
          m_last    = m_win;
          m_data    = m_win ? d1 : d0;
          m_active  = 1'b1;
          m_loading = 1'b1;
        end
      end else if (m_loading) begin
        m_loading = 1'b0;
      end else if (!r[m_win]) begin
        m_active = 1'b0;
      end
      m_ack = 2'b00;
      if (m_active && !m_loading) begin
        m_ack[m_win] = 1'b1;
      end
      exp = {m_loading, m_ack, m_active, m_win, m_data};
      got = snap();
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL random cycle %0d: got %b expected %b", c, got, exp);
      end
    end
  endtask

`ifdef PIPO_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    checks++;
    if (bus.load_cnt !== 8'd0) begin
      fails++;
      $display("FAIL stats_reset: got %0d expected %0d", bus.load_cnt, 0);
    end
    for (int k = 0; k < 260; k++) begin
      bus.req = 2'b01;
      tick();
      bus.req = 2'b00;
      tick();
      tick();
      if (k == 9) begin
        checks++;
        if (bus.load_cnt !== 8'd10) begin
          fails++;
          $display("FAIL stats_count10: got %0d expected %0d", bus.load_cnt, 10);
        end
      end
    end
    checks++;
    if (bus.load_cnt !== 8'd255) begin
      fails++;
      $display("FAIL stats_saturate: got %0d expected %0d", bus.load_cnt, 255);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.load_cnt !== 8'd0) begin
      fails++;
      $display("FAIL stats_clear: got %0d expected %0d", bus.load_cnt, 0);
    end
    tick();
    reset = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_request();
    test_contention();
    test_withdrawn();
    test_reset_mid_ack();
    test_fairness();
    test_random();
`ifdef PIPO_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipo_load_arbiter.md
PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width of the shared PIPO register.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 2, per-requester load request; bit i belongs to requester i.
REQ-005 The block SHALL have port data0, input, WIDTH, requester 0 load data.
REQ-006 The block SHALL have port data1, input, WIDTH, requester 1 load data.
REQ-007 The block SHALL have port ack, output, 2, per-requester completion acknowledge.
REQ-008 The block SHALL have port reg_load, output, 1, load strobe to the shared PIPO register.
REQ-009 The block SHALL have port reg_data, output, WIDTH, data presented to the PIPO register data_in.
REQ-010 The block SHALL have port owner, output, 1, index of the current or most recent grantee.
REQ-011 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, LOAD, ACK.
REQ-013 In IDLE with req nonzero, the block SHALL select a winner, register its data into reg_data, set owner to the winner, and enter LOAD on the next edge.
REQ-014 Arbitration SHALL be round-robin: a sole requester wins; if both request, the requester not equal to the last winner wins.
REQ-015 In LOAD, reg_load SHALL be 1 for exactly one cycle, with reg_data stable; the next state SHALL be ACK unconditionally.
REQ-016 In ACK, ack[owner] SHALL be 1 and the other ack bit 0; the state SHALL remain ACK while req[owner] is 1.
REQ-017 When req[owner] is 0 in ACK, the block SHALL return to IDLE on the next edge; ack SHALL be high for at least one cycle.
REQ-018 A request withdrawn during LOAD SHALL NOT abort the load; one ack cycle SHALL still be issued.
REQ-019 Latency: req rising before edge N SHALL give reg_load high in cycle N..N+1 and ack high from edge N+1.
REQ-020 Requests from the non-owner during LOAD/ACK SHALL be held pending and arbitrated in the next IDLE cycle.
REQ-021 Data inputs SHALL be sampled only at the IDLE->LOAD edge; later changes SHALL NOT affect reg_data.
REQ-022 reg_load, ack, and busy SHALL be outputs of registered state, not combinational from req.

Reset
REQ-023 On reset low, the block SHALL immediately force state IDLE, reg_load=0, ack=00, reg_data=0, owner=0, busy=0, with the round-robin last-winner set to 1 so requester 0 has first priority.
REQ-024 Reset asserted mid-LOAD or mid-ACK SHALL abort the transaction with no further strobe after release.

Configuration
REQ-025 With macro PIPO_ARB_STATS_EN defined, the block SHALL add output load_cnt, 8 bits, which is reset to 0, increments on each LOAD cycle, and saturates at 255.
REQ-026 Without PIPO_ARB_STATS_EN, port load_cnt and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Scenario single request: reset released; req=01, data0=1010 -> reg_load pulse once with reg_data=1010, owner=0, then ack=01 until req drops, then busy=0.
REQ-028 Scenario contention: req=11 from IDLE after reset -> requester 0 served first with data0; after its req drops, requester 1 served with data1=1111 and owner=1.
REQ-029 Scenario fairness: both requesters re-request continuously with four-phase handshakes -> grants alternate 0,1,0,1 and there are no back-to-back grants to the same requester.
REQ-030 Scenario withdrawn request: req=10 for one cycle, then 00 -> one reg_load with data1 and exactly one ack=10 cycle, then IDLE.
REQ-031 Scenario reset mid-ACK: reset low while ack=01 -> all outputs are 0 at once; after release with req=00, no reg_load occurs.
REQ-032 Scenario stats (PIPO_ARB_STATS_EN): 260 completed loads -> load_cnt=255; reset -> load_cnt=0.
